truth_table_sweeper: RTL

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

---
 rtl/truth_table_sweeper.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
`default_nettype none
// ============================================================================
//  Module      : truth_table_sweeper
//  Description : Exhaustive truth-table tester for a 4-input combinational
//                function F(x,y,w,z). A sweep walks the input index 0..15.
//                Each vector is held for SETTLE cycles and then sampled for
//                one cycle. The sampled response is captured into a 16-bit
//                table and compared bit by bit against a golden table.
//  Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Parameters
//    SETTLE     cycles each vector is held before sampling (legal 1..15)
//    EXPECTED   golden truth table, bit i = F(i)
//  Ports
//    clk        single clock, rising-edge active
//    reset      synchronous, active-high reset
//    start      sweep request, sampled only while idle or done
//    s          response of the function under test
//    x,y,w,z    stimulus, {x,y,w,z} = vector index (x is the MSB)
//    busy       sweep in progress
//    done       sweep complete, held until the next accepted start
//    resp_table captured response, bit i = s sampled for index i
//    mismatch   bit i = resp_table[i] ^ EXPECTED[i] for sampled indices
//    err_count  number of mismatching indices, 0..16
//    pass       done with no mismatches (registered)
//
//  The captured-response port is named resp_table because "table" is a
//  reserved word in Verilog/SystemVerilog and cannot be used as a plain
//  identifier.
// ============================================================================
module truth_table_sweeper #(
    parameter int unsigned       SETTLE   = 1,
    parameter logic [15:0]       EXPECTED = 16'hB6A8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        s,
    output logic        x,
    output logic        y,
    output logic        w,
    output logic        z,
    output logic        busy,
    output logic        done,
    output logic [15:0] resp_table,
    output logic [15:0] mismatch,
    output logic [4:0]  err_count,
    output logic        pass
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // The settle counter counts 0..SETTLE-1 while in APPLY; the last value
    // is the one on which APPLY hands over to SAMPLE.
    localparam logic [3:0] C_SETTLE_LAST = 4'(SETTLE - 1);
    localparam logic [3:0] C_LAST_INDEX  = 4'd15;

    // ------------------------------------------------------------------------
    // State machine encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_APPLY  = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Registered state
    // ------------------------------------------------------------------------
    state_t      r_state;
    logic [3:0]  r_index;
    logic [3:0]  r_settle_cnt;
    logic [15:0] r_table;
    logic [15:0] r_mismatch;
    logic [4:0]  r_err_count;
    logic        r_pass;

    // ------------------------------------------------------------------------
    // Next-state values
    // ------------------------------------------------------------------------
    state_t      w_state_nxt;
    logic [3:0]  w_index_nxt;
    logic [3:0]  w_settle_nxt;
    logic [15:0] w_table_nxt;
    logic [15:0] w_mismatch_nxt;
    logic [4:0]  w_err_count_nxt;
    logic        w_pass_nxt;

    // Comparison of the live response against the golden bit for the vector
    // currently applied. Only consumed in SAMPLE.
    logic        w_miss;
    logic [4:0]  w_err_sampled;

    assign w_miss        = s ^ EXPECTED[r_index];
    // At most 16 samples per sweep, each adding at most one, so the 5-bit
    // count tops out at 16 and cannot overflow.
    assign w_err_sampled = r_err_count + {4'd0, w_miss};

    // ------------------------------------------------------------------------
    // State register (reset has priority over everything, including start)
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_index      <= 4'd0;
            r_settle_cnt <= 4'd0;
            r_table      <= 16'd0;
            r_mismatch   <= 16'd0;
            r_err_count  <= 5'd0;
            r_pass       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_index      <= w_index_nxt;
            r_settle_cnt <= w_settle_nxt;
            r_table      <= w_table_nxt;
            r_mismatch   <= w_mismatch_nxt;
            r_err_count  <= w_err_count_nxt;
            r_pass       <= w_pass_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and datapath logic
    // ------------------------------------------------------------------------
    always_comb begin
        // Default: everything holds its value.
        w_state_nxt     = r_state;
        w_index_nxt     = r_index;
        w_settle_nxt    = r_settle_cnt;
        w_table_nxt     = r_table;
        w_mismatch_nxt  = r_mismatch;
        w_err_count_nxt = r_err_count;
        w_pass_nxt      = r_pass;

        case (r_state)
            // IDLE and DONE accept start identically: a new sweep always
            // begins from a clean slate, so results of the previous sweep
            // are dropped on the accept edge.
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_state_nxt     = ST_APPLY;
                    w_index_nxt     = 4'd0;
                    w_settle_nxt    = 4'd0;
                    w_table_nxt     = 16'd0;
                    w_mismatch_nxt  = 16'd0;
                    w_err_count_nxt = 5'd0;
                    w_pass_nxt      = 1'b0;
                end
            end

            // Hold the vector for SETTLE cycles. start is not looked at
            // here or in SAMPLE, so a start pulse mid-sweep is harmless.
            ST_APPLY: begin
                if (r_settle_cnt == C_SETTLE_LAST) begin
                    w_state_nxt = ST_SAMPLE;
                end else begin
                    w_settle_nxt = r_settle_cnt + 4'd1;
                end
            end

            // One-cycle capture of the response for the current index.
            ST_SAMPLE: begin
                w_table_nxt[r_index]    = s;
                w_mismatch_nxt[r_index] = w_miss;
                w_err_count_nxt         = w_err_sampled;
                if (r_index == C_LAST_INDEX) begin
                    // Index stays at 15 so the stimulus reads 4'b1111 in
                    // DONE. pass is resolved here from the final count so
                    // it is valid in the same cycle done rises.
                    w_state_nxt = ST_DONE;
                    w_pass_nxt  = (w_err_sampled == 5'd0);
                end else begin
                    w_state_nxt  = ST_APPLY;
                    w_index_nxt  = r_index + 4'd1;
                    w_settle_nxt = 4'd0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Outputs (all driven straight from registers)
    // ------------------------------------------------------------------------
    assign {x, y, w, z} = r_index;
    assign busy         = (r_state == ST_APPLY) || (r_state == ST_SAMPLE);
    assign done         = (r_state == ST_DONE);
    assign resp_table   = r_table;
    assign mismatch     = r_mismatch;
    assign err_count    = r_err_count;
    assign pass         = r_pass;

endmodule
`default_nettype wire
